// File: rtl/dso_pkg.sv
// Shared constants and types for the DSO display path.
// Holds the VGA timing, the palette and the snapshot FSM state type.
package dso_pkg;
    localparam int H_VIS = 640;
    localparam int H_TOT = 800;
    localparam int V_VIS = 480;
    localparam int V_TOT = 525;

    localparam logic [2:0] COL_BG    = 3'b000;
    localparam logic [2:0] COL_TRACE = 3'b111;
    localparam logic [2:0] COL_GRID  = 3'b001;

    typedef enum logic {
        S_WAIT_VB,
        S_SNAP
    } snap_state_t;
endpackage

// File: rtl/wave_scale.sv
// Combinational map from an unsigned ADC code to a screen row.
// Full scale lands on row 0 and code 0 on the bottom visible row.
module wave_scale
    import dso_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic [DW-1:0] sample,
    output logic [10:0]   row
);
    logic [22:0] prod;

    always_comb begin
        prod = 23'(sample) * 23'(V_VIS);
        row  = 11'(V_VIS - 1) - 11'(prod >> DW);
    end
endmodule

// File: rtl/wave_renderer.sv
// Read side of the DSO sample RAM: per-frame snapshot handshake, per-pixel
// sample fetch and trace/graticule rendering into a registered rgb output.
module wave_renderer
    import dso_pkg::*;
#(
    parameter int AW   = 15,
    parameter int DW   = 12,
    parameter int GRID = 64
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          pixel_tick,
    input  logic          video_on,
    input  logic [10:0]   pix_x,
    input  logic [10:0]   pix_y,
    input  logic          hold,
    output logic          snap_req,
    input  logic          snap_ack,
    input  logic [AW-1:0] snap_base,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [2:0]    rgb,
    output logic          stale
);
    localparam int GB = $clog2(GRID);

    snap_state_t   state_reg, state_next;
    logic [AW-1:0] base_reg, base_next;
    logic          snap_req_reg, snap_req_next;
    logic          stale_reg, stale_next;
    logic [AW-1:0] rd_addr_reg;
    logic [10:0]   y_prv_reg, y_cur_reg;
    logic [10:0]   y_nxt;
    logic [10:0]   y_lo, y_hi;
    logic          primed_reg;
    logic [2:0]    rgb_reg, rgb_next;

    logic vblank_start, snap_timeout, prime_addr, prime_data, col_tick;

    // y_nxt is the scaled read-port data itself: with ticks only two clocks
    // apart a registered copy would land on the same edge that consumes it.
    wave_scale #(.DW(DW)) u_scale (
        .sample (rd_data),
        .row    (y_nxt)
    );

    always_comb begin
        vblank_start = pixel_tick && (pix_y == 11'(V_VIS)) && (pix_x == 11'd0);
        snap_timeout = pixel_tick && (pix_y == 11'(V_TOT - 1)) && (pix_x == 11'(H_TOT - 2));
        prime_addr   = pixel_tick && (pix_x == 11'(H_TOT - 2));
        prime_data   = pixel_tick && (pix_x == 11'(H_TOT - 1));
        col_tick     = pixel_tick && (pix_x < 11'(H_VIS));
    end

    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        snap_req_next = snap_req_reg;
        stale_next    = stale_reg;
        case (state_reg)
            S_WAIT_VB: begin
                if (vblank_start && !hold) begin
                    state_next    = S_SNAP;
                    snap_req_next = 1'b1;
                end
            end
            S_SNAP: begin
                if (snap_ack) begin
                    base_next     = snap_base;
                    snap_req_next = 1'b0;
                    stale_next    = 1'b0;
                    state_next    = S_WAIT_VB;
                end else if (snap_timeout) begin
                    snap_req_next = 1'b0;
                    stale_next    = 1'b1;
                    state_next    = S_WAIT_VB;
                end
            end
            default: state_next = S_WAIT_VB;
        endcase
    end

    always_comb begin
        y_lo     = (y_prv_reg < y_cur_reg) ? y_prv_reg : y_cur_reg;
        y_hi     = (y_prv_reg < y_cur_reg) ? y_cur_reg : y_prv_reg;
        rgb_next = COL_BG;
        // Stay black after reset until a line has been primed with real samples.
        if (video_on && primed_reg) begin
            if (pix_y >= y_lo && pix_y <= y_hi) begin
                rgb_next = COL_TRACE;
            end else if (pix_x[GB-1:0] == '0 || pix_y[GB-1:0] == '0) begin
                rgb_next = COL_GRID;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= S_WAIT_VB;
            base_reg     <= '0;
            snap_req_reg <= 1'b0;
            stale_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            y_prv_reg    <= 11'(V_VIS - 1);
            y_cur_reg    <= 11'(V_VIS - 1);
            primed_reg   <= 1'b0;
            rgb_reg      <= COL_BG;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            snap_req_reg <= snap_req_next;
            stale_reg    <= stale_next;
            if (pixel_tick) begin
                rgb_reg <= rgb_next;
            end
            // base_next so an ack coinciding with the priming tick is used at once.
            if (prime_addr) begin
                rd_addr_reg <= base_next;
            end else if (prime_data) begin
                y_prv_reg   <= y_nxt;
                y_cur_reg   <= y_nxt;
                rd_addr_reg <= base_reg + AW'(1);
                primed_reg  <= 1'b1;
            end else if (col_tick) begin
                y_prv_reg   <= y_cur_reg;
                y_cur_reg   <= y_nxt;
                rd_addr_reg <= base_reg + AW'(pix_x) + AW'(2);
            end
        end
    end

    assign snap_req = snap_req_reg;
    assign stale    = stale_reg;
    assign rd_addr  = rd_addr_reg;
    assign rgb      = rgb_reg;
endmodule
